// File: rtl/core_dispatch_sched.sv
// core_dispatch_sched: hands convolution tiles to NUM_CORE compute cores.
// A free core is granted round-robin on loader request. The core's start
// pulse fires once loading completes. Tiles retire on per-core done pulses.
// A one-cycle done pulse marks the end of the layer.
`timescale 1ns/1ps

module core_dispatch_sched #(
  parameter int unsigned NUM_CORE      = 4,
  parameter int unsigned TILE_CNT_W    = 12,
  localparam int unsigned LOG2_NUM_CORE = $clog2(NUM_CORE)
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     start,
  input  logic [TILE_CNT_W-1:0]    total_tiles,
  input  logic                     core_req,
  output logic                     core_gnt,
  output logic [LOG2_NUM_CORE-1:0] core_gnt_id,
  input  logic                     load_done,
  output logic [NUM_CORE-1:0]      which_core_start,
  input  logic [NUM_CORE-1:0]      which_core_done,
  output logic [NUM_CORE-1:0]      core_busy,
  output logic [TILE_CNT_W-1:0]    tiles_issued,
  output logic [TILE_CNT_W-1:0]    tiles_completed,
  output logic                     done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_LOAD,
    S_FIRE,
    S_WAIT_ALL,
    S_DONE
  } state_e;

  state_e                   state_q, state_d;
  logic [LOG2_NUM_CORE-1:0] rr_q, rr_d;
  logic [TILE_CNT_W-1:0]    total_q, total_d;
  logic [NUM_CORE-1:0]      busy_q, busy_d;
  logic                     gnt_q, gnt_d;
  logic [LOG2_NUM_CORE-1:0] gnt_id_q, gnt_id_d;
  logic [NUM_CORE-1:0]      start_q, start_d;
  logic [TILE_CNT_W-1:0]    issued_q, issued_d;
  logic [TILE_CNT_W-1:0]    completed_q, completed_d;
  logic                     done_q, done_d;

  logic                     found;
  logic [LOG2_NUM_CORE-1:0] free_id;
  logic [LOG2_NUM_CORE-1:0] cand;
  logic [NUM_CORE-1:0]      accepted;
  logic [LOG2_NUM_CORE:0]   pop;
  logic [TILE_CNT_W-1:0]    issued_inc;

  assign issued_inc = issued_q + TILE_CNT_W'(1);

  // First free core scanning from rr_q upward, using busy flags from the start of the cycle.
  always_comb begin
    found   = 1'b0;
    free_id = '0;
    cand    = '0;
    for (int unsigned off = 0; off < NUM_CORE; off++) begin
      cand = LOG2_NUM_CORE'((32'(rr_q) + off) % NUM_CORE);
      if (!found && !busy_q[cand]) begin
        found   = 1'b1;
        free_id = cand;
      end
    end
  end

  // Accepted completions: busy cores only, never the pending core before its start pulse.
  always_comb begin
    accepted = '0;
    if (state_q != S_IDLE) begin
      accepted = which_core_done & busy_q;
      if (state_q == S_LOAD || state_q == S_FIRE) begin
        accepted[gnt_id_q] = 1'b0;
      end
    end
    pop = '0;
    for (int unsigned i = 0; i < NUM_CORE; i++) begin
      pop = pop + {{LOG2_NUM_CORE{1'b0}}, accepted[i]};
    end
  end

  // Next-state and output logic. Pulse outputs default low every cycle.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    total_d     = total_q;
    gnt_d       = 1'b0;
    gnt_id_d    = gnt_id_q;
    start_d     = '0;
    issued_d    = issued_q;
    done_d      = 1'b0;
    busy_d      = busy_q & ~accepted;
    completed_d = completed_q + TILE_CNT_W'(pop);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          total_d     = total_tiles;
          issued_d    = '0;
          completed_d = '0;
          state_d     = (total_tiles == '0) ? S_DONE : S_ARB;
        end
      end
      S_ARB: begin
        // A grant targets a core that was free in busy_q, so it can never
        // collide with a core being cleared in this same cycle.
        if (core_req && found) begin
          gnt_d          = 1'b1;
          gnt_id_d       = free_id;
          busy_d[free_id] = 1'b1;
          rr_d           = LOG2_NUM_CORE'((32'(free_id) + 32'd1) % NUM_CORE);
          state_d        = S_LOAD;
        end
      end
      S_LOAD: begin
        if (load_done) begin
          state_d = S_FIRE;
        end
      end
      S_FIRE: begin
        start_d[gnt_id_q] = 1'b1;
        issued_d          = issued_inc;
        state_d           = (issued_inc == total_q) ? S_WAIT_ALL : S_ARB;
      end
      S_WAIT_ALL: begin
        if (completed_q == total_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset clears everything, in-flight tiles included.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      rr_q        <= '0;
      total_q     <= '0;
      busy_q      <= '0;
      gnt_q       <= 1'b0;
      gnt_id_q    <= '0;
      start_q     <= '0;
      issued_q    <= '0;
      completed_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      total_q     <= total_d;
      busy_q      <= busy_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      start_q     <= start_d;
      issued_q    <= issued_d;
      completed_q <= completed_d;
      done_q      <= done_d;
    end
  end

  assign core_gnt         = gnt_q;
  assign core_gnt_id      = gnt_id_q;
  assign which_core_start = start_q;
  assign core_busy        = busy_q;
  assign tiles_issued     = issued_q;
  assign tiles_completed  = completed_q;
  assign done             = done_q;

endmodule

// File: tb/tb_core_dispatch_sched.sv
// Directed bench for core_dispatch_sched with a simple loader/core responder:
// load_done two cycles after a grant, and optionally a core done four cycles after its start.
`timescale 1ns/1ps

module tb_core_dispatch_sched;

  localparam int unsigned NC = 4;
  localparam int unsigned TW = 12;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic [TW-1:0] total_tiles;
  logic          core_req;
  logic          core_gnt;
  logic [1:0]    core_gnt_id;
  logic          load_done;
  logic [NC-1:0] which_core_start;
  logic [NC-1:0] which_core_done;
  logic [NC-1:0] core_busy;
  logic [TW-1:0] tiles_issued;
  logic [TW-1:0] tiles_completed;
  logic          done;

  always #5 clk = ~clk;

  core_dispatch_sched #(
    .NUM_CORE   (NC),
    .TILE_CNT_W (TW)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .start            (start),
    .total_tiles      (total_tiles),
    .core_req         (core_req),
    .core_gnt         (core_gnt),
    .core_gnt_id      (core_gnt_id),
    .load_done        (load_done),
    .which_core_start (which_core_start),
    .which_core_done  (which_core_done),
    .core_busy        (core_busy),
    .tiles_issued     (tiles_issued),
    .tiles_completed  (tiles_completed),
    .done             (done)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] gnt_pack;
  int          gnt_n;
  logic [63:0] st_pack;
  int          st_n;
  int          done_cnt;
  int          cmp_at_done;
  int          ld_timer;
  int          cd_timer[NC];
  bit          auto_ld;
  bit          auto_cd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {28'd0, core_gnt, core_gnt_id, which_core_start, core_busy,
              tiles_issued, tiles_completed, done}, 64'd0);
  endtask

  task automatic clear_logs();
    gnt_pack    = '0;
    gnt_n       = 0;
    st_pack     = '0;
    st_n        = 0;
    done_cnt    = 0;
    cmp_at_done = -1;
  endtask

  task automatic clear_timers();
    ld_timer = 0;
    for (int i = 0; i < NC; i++) cd_timer[i] = 0;
  endtask

  // One clock: observe outputs after the edge, log events, drive responder inputs.
  task automatic cyc();
    logic [NC-1:0] cd_vec;
    @(posedge clk);
    #1;
    if (core_gnt) begin
      gnt_pack = (gnt_pack << 4) | 64'(core_gnt_id);
      gnt_n++;
    end
    if (which_core_start != '0) begin
      st_pack = (st_pack << 4) | 64'(which_core_start);
      st_n++;
    end
    if (done) begin
      done_cnt++;
      cmp_at_done = int'(tiles_completed);
    end
    load_done = 1'b0;
    if (ld_timer > 0) begin
      ld_timer--;
      if (ld_timer == 0) load_done = 1'b1;
    end
    if (core_gnt && auto_ld) ld_timer = 2;
    cd_vec = '0;
    for (int i = 0; i < NC; i++) begin
      if (cd_timer[i] > 0) begin
        cd_timer[i]--;
        if (cd_timer[i] == 0) cd_vec[i] = 1'b1;
      end
      if (which_core_start[i] && auto_cd) cd_timer[i] = 4;
    end
    which_core_done = cd_vec;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int base;
    int n;
    base = done_cnt;
    n    = 0;
    while (done_cnt == base && n < budget) begin
      cyc();
      n++;
    end
    chk(tag, 64'(done_cnt != base), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset with start and all dones asserted
    resetn          = 1'b0;
    start           = 1'b1;
    total_tiles     = 12'd5;
    core_req        = 1'b0;
    load_done       = 1'b0;
    which_core_done = 4'b1111;
    auto_ld         = 1'b1;
    auto_cd         = 1'b0;
    clear_logs();
    clear_timers();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset_hold");
    start           = 1'b0;
    which_core_done = '0;
    resetn          = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk_zero($sformatf("idle%0d", i));
    end

    // 2: three-tile layer with responding cores
    clear_logs();
    auto_cd     = 1'b1;
    total_tiles = 12'd3;
    core_req    = 1'b1;
    start       = 1'b1;
    cyc();
    start = 1'b0;
    wait_done("t2_done_seen", 60);
    repeat (3) cyc();
    chk("t2_gnt_n", 64'(gnt_n), 64'd3);
    chk("t2_gnt_ids", gnt_pack, 64'h012);
    chk("t2_start_n", 64'(st_n), 64'd3);
    chk("t2_starts", st_pack, 64'h124);
    chk("t2_issued", 64'(tiles_issued), 64'd3);
    chk("t2_cmp_at_done", 64'(cmp_at_done), 64'd3);
    chk("t2_done_once", 64'(done_cnt), 64'd1);
    chk("t2_busy_idle", 64'(core_busy), 64'd0);

    // 3: six-tile layer, no core completes on its own
    resetn = 1'b0;
    clear_timers();
    cyc();
    resetn = 1'b1;
    clear_logs();
    auto_cd     = 1'b0;
    total_tiles = 12'd6;
    core_req    = 1'b1;
    start       = 1'b1;
    cyc();
    start = 1'b0;
    repeat (30) cyc();
    chk("t3_gnt_n", 64'(gnt_n), 64'd4);
    chk("t3_gnt_ids", gnt_pack, 64'h0123);
    chk("t3_busy_full", 64'(core_busy), 64'hf);
    chk("t3_issued4", 64'(tiles_issued), 64'd4);
    chk("t3_gnt_low", 64'(core_gnt), 64'd0);

    clear_logs();
    which_core_done = 4'b0100;
    cyc();
    chk("t3_cmp1", 64'(tiles_completed), 64'd1);
    chk("t3_busy_1011", 64'(core_busy), 64'hb);
    repeat (11) cyc();
    chk("t3_regrant_n", 64'(gnt_n), 64'd1);
    chk("t3_regrant_id2", gnt_pack, 64'h2);
    chk("t3_start_core2", st_pack, 64'h4);
    chk("t3_issued5", 64'(tiles_issued), 64'd5);

    clear_logs();
    which_core_done = 4'b0001;
    cyc();
    repeat (11) cyc();
    chk("t3_regrant2_n", 64'(gnt_n), 64'd1);
    chk("t3_regrant_id0", gnt_pack, 64'h0);
    chk("t3_start_core0", st_pack, 64'h1);
    chk("t3_issued6", 64'(tiles_issued), 64'd6);
    chk("t3_cmp2", 64'(tiles_completed), 64'd2);
    chk("t3_busy_full2", 64'(core_busy), 64'hf);

    // 4: three simultaneous completions
    which_core_done = 4'b1011;
    cyc();
    chk("t4_cmp5", 64'(tiles_completed), 64'd5);
    chk("t4_busy_0100", 64'(core_busy), 64'h4);

    // 5: done on a free core is ignored
    which_core_done = 4'b1000;
    cyc();
    chk("t5_free_cmp", 64'(tiles_completed), 64'd5);
    chk("t5_free_busy", 64'(core_busy), 64'h4);

    clear_logs();
    which_core_done = 4'b0100;
    cyc();
    chk("t5_cmp6", 64'(tiles_completed), 64'd6);
    chk("t5_busy0", 64'(core_busy), 64'd0);
    wait_done("t5_layer_done", 10);

    // 5: done on the pending core while it is still loading
    clear_logs();
    auto_ld     = 1'b0;
    total_tiles = 12'd2;
    core_req    = 1'b1;
    start       = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    chk("t5_gnt", 64'(core_gnt), 64'd1);
    chk("t5_gnt_id1", 64'(core_gnt_id), 64'd1);
    chk("t5_busy_0010", 64'(core_busy), 64'h2);
    which_core_done = 4'b1010;
    cyc();
    chk("t5_load_cmp", 64'(tiles_completed), 64'd0);
    chk("t5_load_busy", 64'(core_busy), 64'h2);
    cyc();
    chk("t5_no_start", 64'(st_n), 64'd0);

    // 6: reset during LOAD
    resetn = 1'b0;
    #1;
    chk_zero("t6_async_reset");
    clear_timers();
    cyc();
    resetn  = 1'b1;
    auto_ld = 1'b1;
    clear_logs();
    repeat (6) cyc();
    chk("t6_no_start", 64'(st_n), 64'd0);
    chk("t6_no_gnt", 64'(gnt_n), 64'd0);
    chk_zero("t6_idle_zero");

    // 6: empty layer
    clear_logs();
    total_tiles = 12'd0;
    start       = 1'b1;
    cyc();
    start = 1'b0;
    chk("t6_done_not_yet", 64'(done), 64'd0);
    cyc();
    chk("t6_done_pulse", 64'(done), 64'd1);
    cyc();
    chk("t6_done_cleared", 64'(done), 64'd0);
    chk("t6_zero_gnts", 64'(gnt_n), 64'd0);
    chk("t6_zero_issued", 64'(tiles_issued), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/core_dispatch_sched.md
Name: core_dispatch_sched

Overview:
- Schedules convolution tiles onto NUM_CORE compute cores and tracks which cores are busy.
- The activation/weight loader requests a core; this block grants a free core round-robin, fires that core's start pulse once loading completes, and retires tiles on core done pulses.
- Asserts done once every tile of a layer has been dispatched and completed.

Parameters:
NUM_CORE, 4, number of compute cores (>=2)
TILE_CNT_W, 12, width of tile counters
LOG2_NUM_CORE, $clog2(NUM_CORE), width of core index (derived, localparam)

Ports:
clk  input  1  system clock
resetn  input  1  reset; one clock, asynchronous, active-low
start  input  1  layer start pulse; sampled only in IDLE
total_tiles  input  TILE_CNT_W  tiles in layer; latched on accepted start
core_req  input  1  loader requests a core (level)
core_gnt  output  1  one-cycle grant pulse
core_gnt_id  output  LOG2_NUM_CORE  granted core index; held until next grant
load_done  input  1  loader finished filling the granted core's row memories (pulse)
which_core_start  output  NUM_CORE  one-hot start pulse to cores
which_core_done  input  NUM_CORE  per-core completion pulses
core_busy  output  NUM_CORE  busy flags
tiles_issued  output  TILE_CNT_W  tiles started this layer
tiles_completed  output  TILE_CNT_W  tiles retired this layer
done  output  1  one-cycle pulse, layer complete

Behaviour:
- All outputs are registered. On reset every output, rr_ptr, latched total, pending id and state are 0; state = IDLE.
- States: IDLE, ARB, LOAD, FIRE, WAIT_ALL, DONE.
- IDLE:
  - On start, latch total_tiles and clear tiles_issued and tiles_completed.
  - If total_tiles==0, go to DONE; else go to ARB.
  - start in any other state is ignored.
- ARB:
  - If core_req=1 and at least one core_busy bit is 0, pick the first free core scanning rr_ptr, rr_ptr+1, ... modulo NUM_CORE.
  - Registered effects: core_gnt=1 for one cycle, core_gnt_id=id, core_busy[id]=1, rr_ptr=(id+1) mod NUM_CORE; go to LOAD.
  - Grant appears the cycle after the qualifying ARB cycle.
  - With no request or no free core, remain in ARB with core_gnt=0.
  - The free-core search uses core_busy as registered at the start of the cycle.
- LOAD: wait for load_done. A load_done seen in any other state is ignored.
- FIRE (one cycle):
  - which_core_start[core_gnt_id]=1 for exactly one cycle; tiles_issued += 1.
  - Next state is WAIT_ALL if the new tiles_issued equals the latched total, else ARB.
- WAIT_ALL: when tiles_completed equals the latched total, go to DONE.
- DONE: done=1 for one cycle, then IDLE. core_busy is all-zero at this point by construction.
- Completion handling, every non-IDLE cycle:
  - For each bit i with which_core_done[i]=1 and core_busy[i]=1, clear core_busy[i].
  - tiles_completed += popcount of those accepted bits; multiple simultaneous dones count in the same cycle.
  - Done pulses on non-busy cores are ignored.
  - Done on core_gnt_id while in LOAD or FIRE is ignored (core not yet started).
  - which_core_done in IDLE is ignored.
- Invariant: tiles_completed <= tiles_issued <= latched total; counters never wrap.
- A done clearing core k and a grant in the same cycle cannot target k; k becomes eligible the following cycle.
- Reset mid-operation returns immediately to reset values; no start pulse is emitted and in-flight tiles are forgotten.

Test Plan:
1. Reset with resetn=0 while start=1, which_core_done=4'b1111 -> all outputs 0 and state IDLE; after release, 5 idle cycles with no activity keep all outputs 0.
2. total_tiles=3, core_req held, load_done 2 cycles after each grant, each core returns done 4 cycles after start -> grant ids 0,1,2; which_core_start 0001, 0010, 0100; tiles_issued=3; done pulses once, when tiles_completed reaches 3.
3. total_tiles=6, no dones -> 4 grants (ids 0-3), core_busy=1111, core_gnt stays 0 in ARB. Then which_core_done=0100 -> next grant id 2; then done 0001 -> grant id 0.
4. Busy=1111, which_core_done=1011 in one cycle -> tiles_completed increments by 3 in one cycle; core_busy=0100.
5. which_core_done=1000 while core 3 is free, plus done on the pending core during LOAD -> tiles_completed unchanged, busy unchanged.
6. total_tiles=0 -> done pulse 2 cycles after start and no grants. Separately, total_tiles=2 with resetn pulsed low during LOAD -> all outputs 0, no which_core_start, IDLE.
